// File: rtl/pulse_train_gen_pkg.sv
// rtl/pulse_train_gen_pkg.sv - shared state encoding and width default for the pulse train generator
package pulse_train_gen_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// rtl/pulse_train_gen_phase_counter.sv - loadable down-counter timing one HIGH or LOW phase
module pulse_train_gen_phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal count marks the last cycle of the phase currently being timed.
  assign tc = (count_q <= CNT_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - configurable pulse train generator with abort and completion strobe
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [CNT_W-1:0] pulse_num,
  output logic             pulse_out,
  output logic             rising_edge,
  output logic             falling_edge,
  output logic             busy,
  output logic             done
);

  state_t state_q, state_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic pulse_out_q, pulse_out_d;
  logic rising_q, rising_d;
  logic falling_q, falling_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic             ph_load;
  logic             ph_dec;
  logic [CNT_W-1:0] ph_load_val;
  logic             ph_tc;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  pulse_train_gen_phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (ph_load),
    .dec     (ph_dec),
    .load_val(ph_load_val),
    .tc      (ph_tc)
  );

  always_comb begin
    state_d     = state_q;
    high_d      = high_q;
    low_d       = low_q;
    num_d       = num_q;
    pulse_cnt_d = pulse_cnt_q;
    ph_load     = 1'b0;
    ph_dec      = 1'b0;
    ph_load_val = high_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          high_d      = at_least_one(high_cycles);
          low_d       = at_least_one(low_cycles);
          num_d       = pulse_num;
          pulse_cnt_d = '0;
          ph_load     = 1'b1;
          ph_load_val = at_least_one(high_cycles);
          state_d     = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ph_tc) begin
          ph_load     = 1'b1;
          ph_load_val = low_q;
          state_d     = ST_LOW;
          // Saturate so a finite train can never wrap back below pulse_num.
          if (pulse_cnt_q != '1) begin
            pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
          end
        end else begin
          ph_dec = 1'b1;
        end
      end
      ST_LOW: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ph_tc) begin
          if ((num_q == '0) || (pulse_cnt_q < num_q)) begin
            ph_load     = 1'b1;
            ph_load_val = high_q;
            state_d     = ST_HIGH;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          ph_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output strobes come from the same state transition that updates pulse_out.
    pulse_out_d = (state_d == ST_HIGH);
    rising_d    = (state_d == ST_HIGH) && (state_q != ST_HIGH);
    falling_d   = (state_q == ST_HIGH) && (state_d != ST_HIGH);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      high_q      <= '0;
      low_q       <= '0;
      num_q       <= '0;
      pulse_cnt_q <= '0;
      pulse_out_q <= 1'b0;
      rising_q    <= 1'b0;
      falling_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      high_q      <= high_d;
      low_q       <= low_d;
      num_q       <= num_d;
      pulse_cnt_q <= pulse_cnt_d;
      pulse_out_q <= pulse_out_d;
      rising_q    <= rising_d;
      falling_q   <= falling_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pulse_out    = pulse_out_q;
  assign rising_edge  = rising_q;
  assign falling_edge = falling_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - self-checking bench for pulse_train_gen
module tb_pulse_train_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] high_cycles;
  logic [15:0] low_cycles;
  logic [15:0] pulse_num;
  logic        pulse_out;
  logic        rising_edge;
  logic        falling_edge;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;

  pulse_train_gen #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .pulse_num   (pulse_num),
    .pulse_out   (pulse_out),
    .rising_edge (rising_edge),
    .falling_edge(falling_edge),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a train started in cycle t0 is a periodic waveform of
  // period h+l beginning at t0+1, lasting n periods (forever when n=0).
  longint cyc = 0;
  bit     m_act = 0;
  longint m_t0 = 0;
  longint m_h = 1, m_l = 1, m_n = 0;
  bit     m_prev = 0;
  bit     e_p, e_r, e_f, e_b, e_d;

  function automatic bit m_intrain(longint c);
    return m_act && (c > m_t0) && ((m_n == 0) || ((c - m_t0 - 1) < m_n * (m_h + m_l)));
  endfunction

  function automatic bit m_pulse(longint c);
    return m_intrain(c) && (((c - m_t0 - 1) % (m_h + m_l)) < m_h);
  endfunction

  function automatic bit m_done(longint c);
    return m_act && (m_n != 0) && (c == m_t0 + 1 + m_n * (m_h + m_l));
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic step(input bit s, input bit a, input bit r,
                      input logic [15:0] h, input logic [15:0] l, input logic [15:0] n);
    start = s; abort = a; rst = r;
    high_cycles = h; low_cycles = l; pulse_num = n;
    if (r) begin
      m_act = 0;
      m_prev = 0;
      e_p = 0; e_r = 0; e_f = 0; e_b = 0; e_d = 0;
    end else begin
      if (m_intrain(cyc) && a) begin
        m_act = 0;
      end else if (!m_intrain(cyc) && s && !a) begin
        m_act = 1;
        m_t0 = cyc;
        m_h = (h == 0) ? 1 : longint'(h);
        m_l = (l == 0) ? 1 : longint'(l);
        m_n = longint'(n);
      end
      e_p = m_pulse(cyc + 1);
      e_b = m_intrain(cyc + 1);
      e_d = m_done(cyc + 1);
      e_r = e_p && !m_prev;
      e_f = !e_p && m_prev;
      m_prev = e_p;
    end
    cyc++;
    @(posedge clk);
    #1;
    chk("model_pulse_out", pulse_out, e_p);
    chk("model_rising_edge", rising_edge, e_r);
    chk("model_falling_edge", falling_edge, e_f);
    chk("model_busy", busy, e_b);
    chk("model_done", done, e_d);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 16'd0, 16'd0, 16'd0);
  endtask

  task automatic run_basic(input bit disturb);
    int rises = 0;
    int falls = 0;
    bit exp_p;
    step(1, 0, 0, 16'd2, 16'd3, 16'd3);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        if (disturb && k == 3) step(1, 0, 0, 16'd7, 16'd1, 16'd9);
        else step(0, 0, 0, 16'd9, 16'd9, 16'd9);
      end
      exp_p = (k + 1 == 1) || (k + 1 == 2) || (k + 1 == 6) || (k + 1 == 7) ||
              (k + 1 == 11) || (k + 1 == 12);
      chk("basic_pulse", pulse_out, exp_p);
      chk("basic_done", done, (k + 1 == 16));
      if (rising_edge) rises++;
      if (falling_edge) falls++;
    end
    total_cnt++;
    if (rises != 3 || falls != 3)
      $display("FAIL basic_edge_count: got %0d/%0d expected 3/3", rises, falls);
    else pass_cnt++;
    if (!disturb) begin
      step(1, 0, 0, 16'd1, 16'd1, 16'd1);
      chk("restart_in_done_cycle_rise", rising_edge, 1'b1);
    end
    idle(4);
  endtask

  typedef struct {
    bit s, a;
    logic [15:0] h, l, n;
    bit p, r, f, b, d;
  } vec_t;

  vec_t vecs[8];

  initial begin
    start = 0; abort = 0; rst = 1;
    high_cycles = 0; low_cycles = 0; pulse_num = 0;

    step(0, 0, 1, 16'd0, 16'd0, 16'd0);
    step(0, 0, 1, 16'd0, 16'd0, 16'd0);
    chk("reset_pulse_out", pulse_out, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);

    // Zero lengths act as 1/1; then start+abort together in IDLE.
    vecs[0] = '{1, 0, 16'd0, 16'd0, 16'd2, 1, 1, 0, 1, 0};
    vecs[1] = '{0, 0, 16'd0, 16'd0, 16'd0, 0, 0, 1, 1, 0};
    vecs[2] = '{0, 0, 16'd0, 16'd0, 16'd0, 1, 1, 0, 1, 0};
    vecs[3] = '{0, 0, 16'd0, 16'd0, 16'd0, 0, 0, 1, 1, 0};
    vecs[4] = '{0, 0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0, 1};
    vecs[5] = '{0, 0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0, 0};
    vecs[6] = '{1, 1, 16'd3, 16'd3, 16'd2, 0, 0, 0, 0, 0};
    vecs[7] = '{0, 0, 16'd3, 16'd3, 16'd2, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].s, vecs[i].a, 0, vecs[i].h, vecs[i].l, vecs[i].n);
      chk($sformatf("vec%0d_pulse", i), pulse_out, vecs[i].p);
      chk($sformatf("vec%0d_rise", i), rising_edge, vecs[i].r);
      chk($sformatf("vec%0d_fall", i), falling_edge, vecs[i].f);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].b);
      chk($sformatf("vec%0d_done", i), done, vecs[i].d);
    end

    run_basic(0);
    run_basic(1);

    // Continuous train aborted in HIGH at cycle 10.
    step(1, 0, 0, 16'd4, 16'd4, 16'd0);
    for (int k = 1; k < 10; k++) step(0, 0, 0, 16'd0, 16'd0, 16'd0);
    chk("abort_pre_pulse", pulse_out, 1'b1);
    step(0, 1, 0, 16'd0, 16'd0, 16'd0);
    chk("abort_pulse", pulse_out, 1'b0);
    chk("abort_fall", falling_edge, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    idle(3);

    // Reset mid-HIGH, then start on the first released cycle.
    step(1, 0, 0, 16'd5, 16'd2, 16'd2);
    step(0, 0, 0, 16'd0, 16'd0, 16'd0);
    step(0, 0, 1, 16'd0, 16'd0, 16'd0);
    chk("rst_mid_pulse", pulse_out, 1'b0);
    chk("rst_mid_fall", falling_edge, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    step(1, 0, 0, 16'd5, 16'd2, 16'd2);
    chk("post_rst_rise", rising_edge, 1'b1);
    idle(16);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0,
           16'($urandom_range(0, 4)), 16'($urandom_range(0, 4)), 16'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
